// File: rtl/armleocpu_ptw.sv
// Sv32 page table walker: resolves a 20-bit virtual tag into a 22-bit physical tag with
// up to two PTE reads, reporting page faults for malformed PTEs and access faults for bus problems.
module armleocpu_ptw #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_request,
  input  logic [19:0] virtual_address,
  input  logic [21:0] satp_ppn,
  output logic        busy,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [21:0] resolve_physical_address,
  output logic [7:0]  resolve_access_bits,
  output logic [33:0] m_address,
  output logic [3:0]  m_burstcount,
  input  logic        m_waitrequest,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        level_q, level_d;
  logic [9:0]  vpn0_q, vpn0_d;
  logic [33:0] addr_q, addr_d;
  logic [7:0]  timer_q, timer_d;
  logic        done_q, done_d;
  logic        pf_q, pf_d;
  logic        af_q, af_d;
  logic [21:0] phys_q, phys_d;
  logic [7:0]  bits_q, bits_d;

  logic        fin, fin_pf, fin_af;
  logic        pte_v, pte_r, pte_w, pte_x, pte_a, pte_leaf;
  logic        unused_rsw;

  assign pte_v    = m_readdata[0];
  assign pte_r    = m_readdata[1];
  assign pte_w    = m_readdata[2];
  assign pte_x    = m_readdata[3];
  assign pte_a    = m_readdata[6];
  assign pte_leaf = pte_r | pte_x;
  assign unused_rsw = &{1'b0, m_readdata[9:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      level_q <= 1'b0;
      vpn0_q  <= '0;
      addr_q  <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      pf_q    <= 1'b0;
      af_q    <= 1'b0;
      phys_q  <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      vpn0_q  <= vpn0_d;
      addr_q  <= addr_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      pf_q    <= pf_d;
      af_q    <= af_d;
      phys_q  <= phys_d;
      bits_q  <= bits_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    vpn0_d  = vpn0_q;
    addr_d  = addr_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    pf_d    = pf_q;
    af_d    = af_q;
    phys_d  = phys_q;
    bits_d  = bits_q;
    fin     = 1'b0;
    fin_pf  = 1'b0;
    fin_af  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // The request is ignored during the completion pulse so a held request restarts one cycle later.
        if (resolve_request && !done_q) begin
          level_d = 1'b1;
          vpn0_d  = virtual_address[9:0];
          addr_d  = {satp_ppn, virtual_address[19:10], 2'b00};
          if (addr_d[33:32] != 2'b00) begin
            fin    = 1'b1;
            fin_af = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!m_waitrequest) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (m_readdatavalid) begin
          if (!pte_v || (pte_w && !pte_r)) begin
            fin = 1'b1; fin_pf = 1'b1;
          end else if (pte_leaf && !pte_a) begin
            fin = 1'b1; fin_pf = 1'b1;
          end else if (pte_leaf && level_q && (m_readdata[19:10] != 10'd0)) begin
            fin = 1'b1; fin_pf = 1'b1;
          end else if (pte_leaf) begin
            fin    = 1'b1;
            phys_d = level_q ? {m_readdata[31:20], vpn0_q} : m_readdata[31:10];
            bits_d = m_readdata[7:0];
          end else if (!level_q) begin
            fin = 1'b1; fin_pf = 1'b1;
          end else begin
            level_d = 1'b0;
            addr_d  = {m_readdata[31:10], vpn0_q, 2'b00};
            if (addr_d[33:32] != 2'b00) begin
              fin = 1'b1; fin_af = 1'b1;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          fin = 1'b1; fin_af = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      pf_d    = fin_pf;
      af_d    = fin_af;
    end
  end

  assign busy                     = (state_q != S_IDLE);
  assign m_read                   = (state_q == S_ISSUE);
  assign m_address                = addr_q;
  assign m_burstcount             = 4'd1;
  assign resolve_done             = done_q;
  assign resolve_pagefault        = pf_q;
  assign resolve_accessfault      = af_q;
  assign resolve_physical_address = phys_q;
  assign resolve_access_bits      = bits_q;
  assign dbg_state_o              = state_q;

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Directed bench for armleocpu_ptw: a cycle-stepped memory responder inside a task plus
// hand-computed expectations for each walk.
module tb_armleocpu_ptw;

  logic        clk = 1'b0;
  logic        rst;
  logic        resolve_request;
  logic [19:0] virtual_address;
  logic [21:0] satp_ppn;
  logic        busy, resolve_done, resolve_pagefault, resolve_accessfault;
  logic [21:0] resolve_physical_address;
  logic [7:0]  resolve_access_bits;
  logic [33:0] m_address;
  logic [3:0]  m_burstcount;
  logic        m_waitrequest;
  logic        m_read;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  armleocpu_ptw #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .resolve_request(resolve_request), .virtual_address(virtual_address), .satp_ppn(satp_ppn),
    .busy(busy), .resolve_done(resolve_done), .resolve_pagefault(resolve_pagefault),
    .resolve_accessfault(resolve_accessfault), .resolve_physical_address(resolve_physical_address),
    .resolve_access_bits(resolve_access_bits), .m_address(m_address), .m_burstcount(m_burstcount),
    .m_waitrequest(m_waitrequest), .m_read(m_read), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a walk at the current negedge (cycle T, t=0) and steps cycles until resolve_done.
  task automatic run_walk(input logic [21:0] satp, input logic [19:0] va,
                          input logic [31:0] pte1, input logic [31:0] pte2,
                          input int stall, input bit give_data, input bit hold,
                          output int lat, output int nreads,
                          output logic [33:0] addr1, output logic [33:0] addr2);
    int  stall_left;
    bit  pending;
    bit  in_issue;
    resolve_request = 1'b1;
    satp_ppn        = satp;
    virtual_address = va;
    lat = -1; nreads = 0; addr1 = '0; addr2 = '0;
    stall_left = stall; pending = 0; in_issue = 0;
    for (int t = 1; t <= 400; t++) begin
      @(negedge clk);
      if (t == 1) begin
        resolve_request = hold;
        virtual_address = ~va;
        satp_ppn        = ~satp;
      end
      m_readdatavalid = 1'b0;
      if (pending) begin
        m_readdatavalid = 1'b1;
        m_readdata      = (nreads == 1) ? pte1 : pte2;
        pending         = 0;
      end
      if (resolve_done) begin
        lat = t;
        break;
      end
      if (m_read) begin
        if (!in_issue) begin
          nreads++;
          if (nreads == 1) addr1 = m_address; else addr2 = m_address;
          in_issue = 1;
        end else begin
          check("addr_stable", m_address, (nreads == 1) ? addr1 : addr2);
        end
        if (stall_left > 0) begin
          m_waitrequest = 1'b1;
          stall_left--;
        end else begin
          m_waitrequest = 1'b0;
          in_issue = 0;
          pending  = give_data;
        end
      end else begin
        m_waitrequest = 1'b0;
      end
    end
    m_readdatavalid = 1'b0;
    m_waitrequest   = 1'b0;
    resolve_request = hold;
    check("done_seen", {63'd0, lat >= 0}, 64'd1);
  endtask

  int          lat, nreads, done_count;
  logic [33:0] a1, a2;

  initial begin
    rst = 1'b1; resolve_request = 1'b0; virtual_address = '0; satp_ppn = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state_o, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", resolve_done, 1'b0);
    check("rst_faults", {resolve_pagefault, resolve_accessfault}, 2'b00);
    check("rst_phys", resolve_physical_address, 22'd0);
    check("rst_bits", resolve_access_bits, 8'd0);
    check("rst_maddr", m_address, 34'd0);
    check("rst_mread", m_read, 1'b0);
    check("rst_burst", m_burstcount, 4'd1);
    rst = 1'b0;
    @(negedge clk);

    // Two-level walk, zero wait
    run_walk(22'h00010, 20'h12345, 32'h00020001, 32'h0ABCD0CF, 0, 1, 0, lat, nreads, a1, a2);
    check("two_lat", lat, 5);
    check("two_reads", nreads, 2);
    check("two_addr1", a1, 34'h0_0001_0120);
    check("two_addr2", a2, 34'h0_0008_0D14);
    check("two_phys", resolve_physical_address, 22'h2AF34);
    check("two_bits", resolve_access_bits, 8'hCF);
    check("two_faults", {resolve_pagefault, resolve_accessfault}, 2'b00);
    @(negedge clk);
    check("after_done_low", resolve_done, 1'b0);

    // Superpage
    run_walk(22'h00010, 20'h12345, 32'h200000CF, 32'h0, 0, 1, 0, lat, nreads, a1, a2);
    check("sp_lat", lat, 3);
    check("sp_reads", nreads, 1);
    check("sp_phys", resolve_physical_address, 22'h80345);
    check("sp_faults", {resolve_pagefault, resolve_accessfault}, 2'b00);
    @(negedge clk);

    // Misaligned superpage
    run_walk(22'h00010, 20'h12345, 32'h200004CF, 32'h0, 0, 1, 0, lat, nreads, a1, a2);
    check("mis_lat", lat, 3);
    check("mis_faults", {resolve_pagefault, resolve_accessfault}, 2'b10);
    check("mis_phys_hold", resolve_physical_address, 22'h80345);
    @(negedge clk);

    run_walk(22'h00010, 20'h12345, 32'h00000000, 32'h0, 0, 1, 0, lat, nreads, a1, a2);
    check("inv_faults", {resolve_pagefault, resolve_accessfault}, 2'b10);
    @(negedge clk);
    run_walk(22'h00010, 20'h12345, 32'h00000005, 32'h0, 0, 1, 0, lat, nreads, a1, a2);
    check("wnr_faults", {resolve_pagefault, resolve_accessfault}, 2'b10);
    @(negedge clk);
    run_walk(22'h00010, 20'h12345, 32'h00020001, 32'h0ABCD08F, 0, 1, 0, lat, nreads, a1, a2);
    check("noa_faults", {resolve_pagefault, resolve_accessfault}, 2'b10);
    check("noa_bits_hold", resolve_access_bits, 8'hCF);
    @(negedge clk);
    run_walk(22'h00010, 20'h12345, 32'h00020001, 32'h00020001, 0, 1, 0, lat, nreads, a1, a2);
    check("ptr0_lat", lat, 5);
    check("ptr0_faults", {resolve_pagefault, resolve_accessfault}, 2'b10);
    @(negedge clk);

    // Access faults
    run_walk(22'h100000, 20'h12345, 32'h0, 32'h0, 0, 1, 0, lat, nreads, a1, a2);
    check("badaddr_lat", lat, 1);
    check("badaddr_reads", nreads, 0);
    check("badaddr_faults", {resolve_pagefault, resolve_accessfault}, 2'b01);
    @(negedge clk);
    run_walk(22'h00010, 20'h12345, 32'h0, 32'h0, 0, 0, 0, lat, nreads, a1, a2);
    check("tmo_lat", lat, 257);
    check("tmo_reads", nreads, 1);
    check("tmo_faults", {resolve_pagefault, resolve_accessfault}, 2'b01);
    @(negedge clk);

    // Stalled superpage
    run_walk(22'h00010, 20'h12345, 32'h200000CF, 32'h0, 3, 1, 0, lat, nreads, a1, a2);
    check("stall_lat", lat, 6);
    check("stall_addr", a1, 34'h0_0001_0120);
    check("stall_phys", resolve_physical_address, 22'h80345);
    @(negedge clk);

    // Back-to-back with request held
    run_walk(22'h00010, 20'h12345, 32'h200000CF, 32'h0, 0, 1, 1, lat, nreads, a1, a2);
    check("b2b_lat1", lat, 3);
    @(negedge clk);
    check("b2b_gap_busy", busy, 1'b0);
    check("b2b_gap_mread", m_read, 1'b0);
    run_walk(22'h00010, 20'h00001, 32'h200000CF, 32'h0, 0, 1, 0, lat, nreads, a1, a2);
    check("b2b_lat2", lat, 3);
    check("b2b_phys2", resolve_physical_address, 22'h80001);
    @(negedge clk);

    // Reset in WAIT with late data
    resolve_request = 1'b1; satp_ppn = 22'h00010; virtual_address = 20'h12345;
    @(negedge clk);
    resolve_request = 1'b0;
    check("rw_mread", m_read, 1'b1);
    m_waitrequest = 1'b0;
    @(negedge clk);
    check("rw_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 32'h200000CF;
    check("rw_state", dbg_state_o, 2'd0);
    check("rw_busy0", busy, 1'b0);
    check("rw_mread0", m_read, 1'b0);
    check("rw_phys0", resolve_physical_address, 22'd0);
    check("rw_bits0", resolve_access_bits, 8'd0);
    check("rw_maddr0", m_address, 34'd0);
    done_count = 0;
    for (int i = 0; i < 5; i++) begin
      if (resolve_done) done_count++;
      @(negedge clk);
      m_readdatavalid = 1'b0;
    end
    check("rw_no_done", done_count, 0);
    check("rw_idle", dbg_state_o, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
